// File: rtl/booth_divider.sv
// Sequential signed radix-2 divider: restoring shift-subtract on operand magnitudes,
// then a sign-fix cycle. Companion datapath to the sequential Booth multiplier.
module booth_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvd_q;
  logic             sign_quo_q;
  logic             sign_rem_q;
  logic             dz_q;
  logic             ov_q;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH:0]   rem_sh_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             fit_d;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  always_comb begin
    rem_sh_d  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    fit_d     = (rem_sh_d >= dvs_q);
    rem_d     = fit_d ? (rem_sh_d - dvs_q) : rem_sh_d;
    quo_d     = {quo_q[WIDTH-2:0], fit_d};
    // Most-negative operand negates to itself, which as an unsigned magnitude is correct.
    dvd_mag_d = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag_d = divisor[WIDTH-1]  ? -divisor  : divisor;
    quo_fix_d = sign_quo_q ? -quo_q : quo_q;
    rem_fix_d = sign_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    if (dz_q) begin
      quo_fix_d = '1;
      rem_fix_d = dvd_q;
    end else if (ov_q) begin
      quo_fix_d = MOST_NEG;
      rem_fix_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      dvd_q       <= '0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // The edge that ends DONE is the first IDLE edge, so a held start chains jobs.
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_CALC;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= dvd_mag_d;
            dvs_q      <= {1'b0, dvs_mag_d};
            dvd_q      <= dividend;
            sign_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_rem_q <= dividend[WIDTH-1];
            dz_q       <= (divisor == '0);
            ov_q       <= (dividend == MOST_NEG) && (divisor == '1);
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          quotient_q  <= quo_fix_d;
          remainder_q <= rem_fix_d;
          dbz_q       <= dz_q;
          ovf_q       <= ov_q;
          state_q     <= S_SETTLE;
        end
        // Extra cycle keeps the done pulse on the same cadence as the multiplier.
        S_SETTLE: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed and exhaustive-sweep checks for booth_divider at WIDTH=4.
module tb_booth_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one job and wait (bounded) for done; operands are scrambled after acceptance.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    ov = overflow;
  endtask

  task automatic job_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input logic eov);
    logic [W-1:0] q, r;
    logic         dz, ov;
    int           lat;
    run_job(a, b, q, r, dz, ov, lat);
    check({tag, " latency"}, lat, W + 2);
    check({tag, " quotient"}, q, eq);
    check({tag, " remainder"}, r, er);
    check({tag, " div_by_zero"}, dz, edz);
    check({tag, " overflow"}, ov, eov);
    tick();
    check({tag, " done pulse width"}, done, 0);
    check({tag, " busy released"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er, a, b;
    logic         dz, ov, edz, eov;
    int           lat, dones, busy_low, gap, ia, ib;
    logic [7:0]   pair;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset flags", {div_by_zero, overflow}, 0);
    reset = 1'b1;
    tick();

    // Reset mid-job then a fresh 7/2 job: no stale done pulse.
    dividend = 4'd5;
    divisor  = 4'd1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    reset    = 1'b0;
    tick();
    reset    = 1'b1;
    job_check("7/2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0);

    job_check("-7/2", 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0);
    job_check("7/-2", 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0);
    job_check("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1);
    job_check("5/0", 4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0);
    job_check("6/3", 4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0);

    // start pulsed during CALC must be ignored.
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    dividend = 4'd6;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dones    = 0;
    busy_low = 0;
    q        = '0;
    r        = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(W)) begin
        if (!busy) busy_low++;
      end
      if (done) begin
        dones++;
        q = quotient;
        r = remainder;
      end
      tick();
    end
    check("ignored start done count", dones, 1);
    check("ignored start busy held", busy_low, 0);
    check("ignored start quotient", q, 4'd3);
    check("ignored start remainder", r, 4'd1);

    // Asynchronous reset during CALC clears outputs without waiting for an edge.
    dividend = 4'd7;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async reset quotient", quotient, 0);
    check("async reset remainder", remainder, 0);
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset flags", {div_by_zero, overflow}, 0);
    tick();
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dones++;
    end
    check("no done after abandoned job", dones, 0);

    // start held high: done pulses W+3 cycles apart.
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    lat = 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("back-to-back first done", done, 1);
    tick();
    gap = 1;
    while (!done && gap < 30) begin
      tick();
      gap++;
    end
    check("back-to-back spacing", gap, W + 3);
    check("back-to-back quotient", quotient, 4'd3);
    start = 1'b0;
    lat = 0;
    while (busy && lat < 30) begin
      tick();
      lat++;
    end
    check("back-to-back drained", busy, 0);

    // All operand pairs against integer division (truncating, remainder follows dividend).
    for (int i = 0; i < 256; i++) begin
      pair = 8'(i);
      a    = pair[7:4];
      b    = pair[3:0];
      ia   = int'($signed(a));
      ib   = int'($signed(b));
      if (ib == 0) begin
        eq = '1; er = a; edz = 1'b1; eov = 1'b0;
      end else if (ia == -8 && ib == -1) begin
        eq = 4'b1000; er = '0; edz = 1'b0; eov = 1'b1;
      end else begin
        eq = W'(ia / ib); er = W'(ia % ib); edz = 1'b0; eov = 1'b0;
      end
      run_job(a, b, q, r, dz, ov, lat);
      check($sformatf("sweep %0d/%0d latency", ia, ib), lat, W + 2);
      check($sformatf("sweep %0d/%0d quotient", ia, ib), q, eq);
      check($sformatf("sweep %0d/%0d remainder", ia, ib), r, er);
      check($sformatf("sweep %0d/%0d flags", ia, ib), {dz, ov}, {edz, eov});
      if (!edz && !eov) begin
        check($sformatf("sweep %0d/%0d identity", ia, ib), W'(q * b + r), a);
        if (r != '0) check($sformatf("sweep %0d/%0d rem sign", ia, ib), r[W-1], a[W-1]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
